// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state codes and width helpers.
package pulse_stretcher_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t HIGH = 2'd1;
    localparam state_t LOW  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / level-out bundle between an event source and the pulse stretcher.
interface pulse_stretcher_if #(
    parameter int CNT_W = 2
);
    logic             pulse_i;
    logic             clear_i;
    logic             level_o;
    logic             busy_o;
    logic [CNT_W-1:0] pending_o;
    logic             overflow_o;

    modport master (
        output pulse_i, clear_i,
        input  level_o, busy_o, pending_o, overflow_o
    );

    modport slave (
        input  pulse_i, clear_i,
        output level_o, busy_o, pending_o, overflow_o
    );
endinterface

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// Saturating up/down counter; a simultaneous inc and dec cancel out.
module sat_updown_counter #(
    parameter int MAX = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       inc,
    input  logic                       dec,
    input  logic                       clr,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       full
);
    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && count != MAX_C) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign full = (count == MAX_C);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle events into HIGH_CYCLES-wide windows separated by LOW_CYCLES gaps,
// queueing events that arrive while a window is in flight.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    pulse_stretcher_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int TMR_W = max_int(1, $clog2(max_int(HIGH_CYCLES, LOW_CYCLES)));
    localparam logic [TMR_W-1:0] TMR_HIGH = TMR_W'(HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOW  = TMR_W'(LOW_CYCLES - 1);

    if (HIGH_CYCLES < 1) begin : g_bad_high
        $error("pulse_stretcher: HIGH_CYCLES must be >= 1");
    end
    if (LOW_CYCLES < 1) begin : g_bad_low
        $error("pulse_stretcher: LOW_CYCLES must be >= 1");
    end
    if (MAX_PENDING < 1) begin : g_bad_pend
        $error("pulse_stretcher: MAX_PENDING must be >= 1");
    end

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             level_q, busy_q, ovf_q;
    logic [CNT_W-1:0] pending;
    logic             full;
    logic             accept, low_exit, has_pend, inc, dec, drop;

    assign accept   = bus.pulse_i && !bus.clear_i;
    assign low_exit = (state_q == LOW) && (timer_q == '0);
    assign has_pend = (pending != '0);
    assign dec      = low_exit && has_pend && !bus.clear_i;
    // A pulse on the LOW-exit cycle with nothing queued starts the next window directly.
    assign inc      = accept && (state_q != IDLE) && !(low_exit && !has_pend);
    assign drop     = inc && full && !dec;

    sat_updown_counter #(
        .MAX (MAX_PENDING)
    ) u_pending (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (inc),
        .dec     (dec),
        .clr     (bus.clear_i),
        .count   (pending),
        .full    (full)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (bus.clear_i) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.pulse_i) begin
                        state_d = HIGH;
                        timer_d = TMR_HIGH;
                    end
                end
                HIGH: begin
                    if (timer_q == '0) begin
                        state_d = LOW;
                        timer_d = TMR_LOW;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                LOW: begin
                    if (timer_q == '0) begin
                        if (has_pend || bus.pulse_i) begin
                            state_d = HIGH;
                            timer_d = TMR_HIGH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            level_q <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
            if (bus.clear_i) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.level_o    = level_q;
    assign bus.busy_o     = busy_q;
    assign bus.pending_o  = pending;
    assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random soak against a window-schedule model.
module tb_pulse_stretcher;

    localparam int HA = 3, LA = 2, MA = 2;
    localparam int HB = 1, LB = 1, MB = 2;
    localparam int CWA = $clog2(MA + 1);
    localparam int CWB = $clog2(MB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;

    pulse_stretcher_if #(.CNT_W(CWA)) if_a ();
    pulse_stretcher_if #(.CNT_W(CWB)) if_b ();

    pulse_stretcher #(.HIGH_CYCLES(HA), .LOW_CYCLES(LA), .MAX_PENDING(MA)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_a_n),
        .bus     (if_a)
    );

    pulse_stretcher #(.HIGH_CYCLES(HB), .LOW_CYCLES(LB), .MAX_PENDING(MB)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_b_n),
        .bus     (if_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: each accepted event owns a scheduled window start time.
    int cfg_h [2];
    int cfg_l [2];
    int cfg_m [2];
    int ws    [2][8];
    int wn    [2];
    bit m_ovf [2];
    int acc   [2];
    int drops [2];
    int rises [2];
    bit prev_lvl [2];
    int run_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        wn[i]    = 0;
        m_ovf[i] = 1'b0;
    endtask

    task automatic model_edge(input int i, input bit p, input bit c, input int t);
        int k, last, ns, pend;
        bit dec;
        k = 0;
        for (int j = 0; j < wn[i]; j++) begin
            if (ws[i][j] + cfg_h[i] + cfg_l[i] - 1 >= t + 1) begin
                ws[i][k] = ws[i][j];
                k++;
            end
        end
        wn[i] = k;
        if (c) begin
            wn[i]    = 0;
            m_ovf[i] = 1'b0;
        end else if (p) begin
            last = (wn[i] > 0) ? ws[i][wn[i]-1] : -1000;
            ns   = (t + 1 > last + cfg_h[i] + cfg_l[i]) ? t + 1 : last + cfg_h[i] + cfg_l[i];
            pend = 0;
            dec  = 1'b0;
            for (int j = 0; j < wn[i]; j++) begin
                if (ws[i][j] > t) pend++;
                if (ws[i][j] == t + 1) dec = 1'b1;
            end
            if (ns == t + 1 || pend < cfg_m[i] || dec) begin
                ws[i][wn[i]] = ns;
                wn[i]++;
                acc[i]++;
            end else begin
                m_ovf[i] = 1'b1;
                drops[i]++;
            end
        end
    endtask

    function automatic bit m_level(input int i, input int c);
        for (int j = 0; j < wn[i]; j++)
            if (ws[i][j] <= c && c <= ws[i][j] + cfg_h[i] - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input int i, input int c);
        for (int j = 0; j < wn[i]; j++)
            if (ws[i][j] <= c && c <= ws[i][j] + cfg_h[i] + cfg_l[i] - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pend(input int i, input int c);
        int n = 0;
        for (int j = 0; j < wn[i]; j++)
            if (ws[i][j] > c) n++;
        return n;
    endfunction

    task automatic check_all(input int i);
        logic l, b, o;
        logic [31:0] p;
        if (i == 0) begin
            l = if_a.level_o; b = if_a.busy_o; o = if_a.overflow_o; p = 32'(if_a.pending_o);
            chk("a_level",    32'(l), 32'(m_level(0, cyc)));
            chk("a_busy",     32'(b), 32'(m_busy(0, cyc)));
            chk("a_pending",  p,      32'(m_pend(0, cyc)));
            chk("a_overflow", 32'(o), 32'(m_ovf[0]));
        end else begin
            l = if_b.level_o; b = if_b.busy_o; o = if_b.overflow_o; p = 32'(if_b.pending_o);
            chk("b_level",    32'(l), 32'(m_level(1, cyc)));
            chk("b_busy",     32'(b), 32'(m_busy(1, cyc)));
            chk("b_pending",  p,      32'(m_pend(1, cyc)));
            chk("b_overflow", 32'(o), 32'(m_ovf[1]));
            run_b = (l === 1'b1) ? run_b + 1 : 0;
            chk("b_high_run_le1", 32'(run_b <= 1), 32'd1);
        end
        if (l === 1'b1 && !prev_lvl[i]) rises[i]++;
        prev_lvl[i] = (l === 1'b1);
    endtask

    // Called at a negedge: drive inputs, advance one edge, then check at the next negedge.
    task automatic step(input bit pa, input bit ca, input bit pb, input bit cb);
        if_a.pulse_i = pa; if_a.clear_i = ca;
        if_b.pulse_i = pb; if_b.clear_i = cb;
        @(posedge clk);
        if (rst_a_n) model_edge(0, pa, ca, cyc);
        if (rst_b_n) model_edge(1, pb, cb, cyc);
        cyc++;
        @(negedge clk);
        if (rst_a_n) check_all(0);
        if (rst_b_n) check_all(1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int r0;
        cfg_h[0] = HA; cfg_l[0] = LA; cfg_m[0] = MA;
        cfg_h[1] = HB; cfg_l[1] = LB; cfg_m[1] = MB;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            acc[i] = 0; drops[i] = 0; rises[i] = 0; prev_lvl[i] = 1'b0;
        end
        if_a.pulse_i = 1'b0; if_a.clear_i = 1'b0;
        if_b.pulse_i = 1'b0; if_b.clear_i = 1'b0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level",    32'(if_a.level_o),    32'd0);
        chk("rst_busy",     32'(if_a.busy_o),     32'd0);
        chk("rst_pending",  32'(if_a.pending_o),  32'd0);
        chk("rst_overflow", 32'(if_a.overflow_o), 32'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        idle(3);

        // Single pulse: one window of HA cycles.
        r0 = rises[0];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_level_t1", 32'(if_a.level_o), 32'd1);
        idle(8);
        chk("single_windows", 32'(rises[0] - r0), 32'd1);

        // Two pulses two cycles apart: second one queued and replayed.
        r0 = rises[0];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("two_pending_1", 32'(if_a.pending_o), 32'd1);
        idle(10);
        chk("two_windows", 32'(rises[0] - r0), 32'd2);

        // Four back-to-back pulses: last one dropped, overflow sticks until clear.
        r0 = rises[0];
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_overflow", 32'(if_a.overflow_o), 32'd1);
        idle(15);
        chk("sat_windows", 32'(rises[0] - r0), 32'd3);
        chk("sat_sticky",  32'(if_a.overflow_o), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clear_overflow", 32'(if_a.overflow_o), 32'd0);
        idle(2);

        // Pulse exactly on the LOW-exit cycle starts the next window directly.
        r0 = rises[0];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lowexit_pending", 32'(if_a.pending_o), 32'd0);
        chk("lowexit_level",   32'(if_a.level_o),   32'd1);
        idle(8);
        chk("lowexit_windows", 32'(rises[0] - r0), 32'd2);
        chk("lowexit_ovf",     32'(if_a.overflow_o), 32'd0);

        // Clear with a simultaneous pulse and one queued event.
        r0 = rises[0];
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_level",   32'(if_a.level_o),   32'd0);
        chk("clear_busy",    32'(if_a.busy_o),    32'd0);
        chk("clear_pending", 32'(if_a.pending_o), 32'd0);
        idle(10);
        chk("clear_windows", 32'(rises[0] - r0), 32'd1);

        // Asynchronous reset in the middle of a HIGH window.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(if_a.level_o), 32'd1);
        #2 rst_a_n = 1'b0;
        #1;
        chk("async_rst_level",   32'(if_a.level_o),    32'd0);
        chk("async_rst_busy",    32'(if_a.busy_o),     32'd0);
        chk("async_rst_pending", 32'(if_a.pending_o),  32'd0);
        chk("async_rst_ovf",     32'(if_a.overflow_o), 32'd0);
        model_reset(0);
        prev_lvl[0] = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_a_n = 1'b1;
        idle(3);

        // Random soak: B at 30% pulse density, A random with occasional clears.
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(99, 0) < 35, $urandom_range(99, 0) < 3,
                 $urandom_range(99, 0) < 30, 1'b0);
        end
        idle(12);
        chk("soak_b_edges_vs_accepted", 32'(rises[1] + drops[1]), 32'(acc[1] + drops[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
